// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO types and width helpers
package fifo_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  function automatic int fifo_level_w(input int size);
    return $clog2(size + 1);
  endfunction

  function automatic int fifo_ptr_w(input int size);
    return (size > 2) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - FIFO storage: one synchronous write port, one asynchronous read port
module fifo_mem #(
  parameter int BITS = 32,
  parameter int SIZE = 16,
  parameter int AW   = 4
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [BITS-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [BITS-1:0] rd_data
);

  // Contents are deliberately not reset; validity is tracked by the pointers.
  logic [BITS-1:0] mem_q [SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with thresholds, sticky errors, flush and STD/FWFT read
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int         BITS     = 32,
  parameter int         SIZE     = 16,
  parameter fifo_mode_e MODE     = FIFO_STD,
  parameter int         AF_LEVEL = SIZE - 2,
  parameter int         AE_LEVEL = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          wr_en,
  input  logic [BITS-1:0]               wr_data,
  output logic                          wr_full,
  output logic                          wr_almost_full,
  output logic                          wr_overflow,
  input  logic                          rd_en,
  output logic [BITS-1:0]               rd_data,
  output logic                          rd_valid,
  output logic                          rd_empty,
  output logic                          rd_almost_empty,
  output logic                          rd_underflow,
  output logic [fifo_level_w(SIZE)-1:0] level
);

  localparam int LW = fifo_level_w(SIZE);
  localparam int PW = fifo_ptr_w(SIZE);

  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(SIZE);
  localparam logic [LW-1:0] LVL_AF   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] LVL_AE   = LW'(AE_LEVEL);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(SIZE - 1);

  if (SIZE < 2 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > SIZE) begin : g_bad_params
    $fatal(1, "sync_fifo: illegal SIZE/AF_LEVEL/AE_LEVEL combination");
  end

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            full_q, full_d, empty_q, empty_d;
  logic            af_q, af_d, ae_q, ae_d;
  logic            ovf_q, ovf_d, udf_q, udf_d;
  logic [BITS-1:0] rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic [BITS-1:0] mem_rdata;
  logic            wr_acc, rd_acc;

  assign wr_acc = wr_en & ~full_q & ~clr;
  assign rd_acc = rd_en & ~empty_q & ~clr;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q | (wr_en & full_q);
    udf_d      = udf_q | (rd_en & empty_q);
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;

    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d  = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
      rd_data_d = mem_rdata;
    end
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end

    // Flags track the next-state level so they move in lockstep with it.
    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == '0);
    af_d    = (level_d >= LVL_AF);
    ae_d    = (level_d <= LVL_AE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= (AF_LEVEL == 0);
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  fifo_mem #(
    .BITS (BITS),
    .SIZE (SIZE),
    .AW   (PW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rdata)
  );

  assign wr_full         = full_q;
  assign wr_almost_full  = af_q;
  assign wr_overflow     = ovf_q;
  assign rd_empty        = empty_q;
  assign rd_almost_empty = ae_q;
  assign rd_underflow    = udf_q;
  assign level           = level_q;
  assign rd_data         = (MODE == FIFO_FWFT) ? mem_rdata : rd_data_q;
  assign rd_valid        = (MODE == FIFO_FWFT) ? ~empty_q : rd_valid_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - self-checking bench for sync_fifo (table vectors, directed corners, random vs queue model)
module tb_sync_fifo;
  import fifo_pkg::*;

  localparam int BS = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_clr, a_wr_en, a_rd_en;
  logic [31:0] a_wr_data, a_rd_data;
  logic        a_full, a_af, a_ovf, a_valid, a_empty, a_ae, a_udf;
  logic [4:0]  a_level;

  logic        b_rst_n, b_clr, b_wr_en, b_rd_en;
  logic [31:0] b_wr_data, bs_rd_data, bf_rd_data;
  logic        bs_full, bs_af, bs_ovf, bs_valid, bs_empty, bs_ae, bs_udf;
  logic        bf_full, bf_af, bf_ovf, bf_valid, bf_empty, bf_ae, bf_udf;
  logic [2:0]  bs_level, bf_level;

  sync_fifo #(.BITS(32), .SIZE(16), .MODE(FIFO_STD)) u_a (
    .clk(clk), .rst_n(a_rst_n), .clr(a_clr), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .wr_full(a_full), .wr_almost_full(a_af), .wr_overflow(a_ovf), .rd_en(a_rd_en),
    .rd_data(a_rd_data), .rd_valid(a_valid), .rd_empty(a_empty),
    .rd_almost_empty(a_ae), .rd_underflow(a_udf), .level(a_level)
  );

  sync_fifo #(.BITS(32), .SIZE(BS), .MODE(FIFO_STD), .AF_LEVEL(4), .AE_LEVEL(1)) u_bs (
    .clk(clk), .rst_n(b_rst_n), .clr(b_clr), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .wr_full(bs_full), .wr_almost_full(bs_af), .wr_overflow(bs_ovf), .rd_en(b_rd_en),
    .rd_data(bs_rd_data), .rd_valid(bs_valid), .rd_empty(bs_empty),
    .rd_almost_empty(bs_ae), .rd_underflow(bs_udf), .level(bs_level)
  );

  sync_fifo #(.BITS(32), .SIZE(BS), .MODE(FIFO_FWFT), .AF_LEVEL(4), .AE_LEVEL(1)) u_bf (
    .clk(clk), .rst_n(b_rst_n), .clr(b_clr), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .wr_full(bf_full), .wr_almost_full(bf_af), .wr_overflow(bf_ovf), .rd_en(b_rd_en),
    .rd_data(bf_rd_data), .rd_valid(bf_valid), .rd_empty(bf_empty),
    .rd_almost_empty(bf_ae), .rd_underflow(bf_udf), .level(bf_level)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_b(input string name, input logic got, input logic exp);
    check(name, 32'(got), 32'(exp));
  endtask

  // Reference model for the SIZE=6 pair: a queue of words plus sticky bits.
  logic [31:0] mq[$];
  bit          m_ovf, m_udf, m_sv;
  logic [31:0] m_sd;

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_sv  = 1'b0;
    m_sd  = '0;
  endtask

  task automatic model_step();
    if (b_clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_sv  = 1'b0;
    end else begin
      bit rd_ok, wr_ok;
      rd_ok = b_rd_en && (mq.size() != 0);
      wr_ok = b_wr_en && (mq.size() != BS);
      if (b_wr_en && mq.size() == BS) m_ovf = 1'b1;
      if (b_rd_en && mq.size() == 0) m_udf = 1'b1;
      m_sv = rd_ok;
      if (rd_ok) m_sd = mq.pop_front();
      if (wr_ok) mq.push_back(b_wr_data);
    end
  endtask

  task automatic b_cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic b_flags(input string tag, input int lvl, input bit full, input bit empty,
                         input bit af, input bit ae, input bit ovf, input bit udf);
    check({tag, " s.level"}, 32'(bs_level), 32'(lvl));
    check({tag, " f.level"}, 32'(bf_level), 32'(lvl));
    check_b({tag, " s.full"}, bs_full, full);
    check_b({tag, " f.full"}, bf_full, full);
    check_b({tag, " s.empty"}, bs_empty, empty);
    check_b({tag, " f.empty"}, bf_empty, empty);
    check_b({tag, " s.afull"}, bs_af, af);
    check_b({tag, " f.afull"}, bf_af, af);
    check_b({tag, " s.aempty"}, bs_ae, ae);
    check_b({tag, " f.aempty"}, bf_ae, ae);
    check_b({tag, " s.ovf"}, bs_ovf, ovf);
    check_b({tag, " f.ovf"}, bf_ovf, ovf);
    check_b({tag, " s.udf"}, bs_udf, udf);
    check_b({tag, " f.udf"}, bf_udf, udf);
  endtask

  task automatic model_check(input string tag);
    int n;
    n = mq.size();
    b_flags(tag, n, n == BS, n == 0, n >= 4, n <= 1, m_ovf, m_udf);
    check_b({tag, " s.valid"}, bs_valid, m_sv);
    check({tag, " s.data"}, bs_rd_data, m_sd);
    check_b({tag, " f.valid"}, bf_valid, n != 0);
    if (n != 0) check({tag, " f.data"}, bf_rd_data, mq[0]);
  endtask

  task automatic a_reset_values(input string tag);
    check({tag, " level"}, 32'(a_level), 32'd0);
    check_b({tag, " full"}, a_full, 1'b0);
    check_b({tag, " empty"}, a_empty, 1'b1);
    check_b({tag, " afull"}, a_af, 1'b0);
    check_b({tag, " aempty"}, a_ae, 1'b1);
    check_b({tag, " ovf"}, a_ovf, 1'b0);
    check_b({tag, " udf"}, a_udf, 1'b0);
    check_b({tag, " valid"}, a_valid, 1'b0);
    check({tag, " data"}, a_rd_data, 32'd0);
  endtask

  typedef struct {
    bit          clr, we, re;
    logic [31:0] d;
    int          lvl;
    bit          full, empty, af, ae, ovf, udf, sv;
    logic [31:0] sd, head;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl[NV];

  initial begin
    string tag;

    // clr we re  data      lvl full empty af ae ovf udf sv  sd        head
    tbl[0]  = '{0, 1, 0, 32'h10, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0,  32'h10};
    tbl[1]  = '{0, 1, 0, 32'h11, 2, 0, 0, 0, 0, 0, 0, 0, 32'h0,  32'h10};
    tbl[2]  = '{0, 1, 0, 32'h12, 3, 0, 0, 0, 0, 0, 0, 0, 32'h0,  32'h10};
    tbl[3]  = '{0, 1, 0, 32'h13, 4, 0, 0, 1, 0, 0, 0, 0, 32'h0,  32'h10};
    tbl[4]  = '{0, 1, 0, 32'h14, 5, 0, 0, 1, 0, 0, 0, 0, 32'h0,  32'h10};
    tbl[5]  = '{0, 1, 0, 32'h15, 6, 1, 0, 1, 0, 0, 0, 0, 32'h0,  32'h10};
    tbl[6]  = '{0, 1, 1, 32'h16, 5, 0, 0, 1, 0, 1, 0, 1, 32'h10, 32'h11};
    tbl[7]  = '{0, 0, 0, 32'h0,  5, 0, 0, 1, 0, 1, 0, 0, 32'h0,  32'h11};
    tbl[8]  = '{1, 1, 0, 32'h99, 0, 0, 1, 0, 1, 0, 0, 0, 32'h0,  32'h0};
    tbl[9]  = '{0, 0, 1, 32'h0,  0, 0, 1, 0, 1, 0, 1, 0, 32'h0,  32'h0};
    tbl[10] = '{0, 1, 1, 32'h20, 1, 0, 0, 0, 1, 0, 1, 0, 32'h0,  32'h20};
    tbl[11] = '{0, 0, 1, 32'h0,  0, 0, 1, 0, 1, 0, 1, 1, 32'h20, 32'h0};
    tbl[12] = '{1, 0, 0, 32'h0,  0, 0, 1, 0, 1, 0, 0, 0, 32'h0,  32'h0};

    a_rst_n = 1'b0; a_clr = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0; a_wr_data = '0;
    b_rst_n = 1'b0; b_clr = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_wr_data = '0;
    model_reset();
    repeat (3) @(negedge clk);

    a_reset_values("a.reset");
    model_check("b.reset");
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    @(negedge clk);

    // Five writes then five single reads on the 16-deep standard FIFO.
    for (int i = 0; i < 5; i++) begin
      a_wr_en = 1'b1;
      a_wr_data = 32'hA0 + 32'(i);
      @(posedge clk); @(negedge clk);
      check("a.wr level", 32'(a_level), 32'(i + 1));
    end
    a_wr_en = 1'b0;
    check_b("a.not empty", a_empty, 1'b0);
    for (int i = 0; i < 5; i++) begin
      a_rd_en = 1'b1;
      @(posedge clk); @(negedge clk);
      a_rd_en = 1'b0;
      check_b("a.rd valid", a_valid, 1'b1);
      check("a.rd data", a_rd_data, 32'hA0 + 32'(i));
      check("a.rd level", 32'(a_level), 32'(4 - i));
      @(posedge clk); @(negedge clk);
      check_b("a.valid pulse", a_valid, 1'b0);
      check("a.data hold", a_rd_data, 32'hA0 + 32'(i));
    end
    check_b("a.empty end", a_empty, 1'b1);

    // Asynchronous reset in the middle of a write burst.
    a_wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_wr_data = 32'hB0 + 32'(i);
      @(posedge clk); @(negedge clk);
    end
    a_rd_en = 1'b1;
    @(posedge clk); @(negedge clk);
    #2 a_rst_n = 1'b0;
    #1 a_reset_values("a.async");
    @(negedge clk);
    a_rst_n = 1'b1;
    a_rd_en = 1'b0;
    a_wr_data = 32'h77;
    @(posedge clk); @(negedge clk);
    a_wr_en = 1'b0;
    a_rd_en = 1'b1;
    @(posedge clk); @(negedge clk);
    a_rd_en = 1'b0;
    check("a.post reset data", a_rd_data, 32'h77);
    check("a.post reset level", 32'(a_level), 32'd0);

    // Directed vectors on the 6-deep pair: thresholds, overflow, flush, underflow.
    for (int i = 0; i < NV; i++) begin
      b_clr = tbl[i].clr; b_wr_en = tbl[i].we; b_rd_en = tbl[i].re; b_wr_data = tbl[i].d;
      b_cycle();
      tag = $sformatf("vec%0d", i);
      b_flags(tag, tbl[i].lvl, tbl[i].full, tbl[i].empty, tbl[i].af, tbl[i].ae,
              tbl[i].ovf, tbl[i].udf);
      check_b({tag, " s.valid"}, bs_valid, tbl[i].sv);
      if (tbl[i].sv) check({tag, " s.data"}, bs_rd_data, tbl[i].sd);
      if (!tbl[i].empty) check({tag, " f.data"}, bf_rd_data, tbl[i].head);
    end
    b_clr = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;

    // FWFT: a word written into an empty FIFO shows up without any read request.
    b_wr_en = 1'b1; b_wr_data = 32'h55;
    b_cycle();
    b_wr_en = 1'b0;
    check("fwft data", bf_rd_data, 32'h55);
    check_b("fwft valid", bf_valid, 1'b1);
    b_rd_en = 1'b1;
    b_cycle();
    b_rd_en = 1'b0;
    check_b("fwft popped empty", bf_empty, 1'b1);
    check_b("fwft popped valid", bf_valid, 1'b0);
    model_check("fwft");

    // Concurrent write/read pairs at constant level, wrapping pointers many times.
    for (int i = 0; i < 3; i++) begin
      b_wr_en = 1'b1; b_wr_data = $urandom;
      b_cycle();
      model_check("prefill");
    end
    for (int i = 0; i < 40; i++) begin
      b_wr_en = 1'b1; b_rd_en = 1'b1; b_wr_data = $urandom;
      b_cycle();
      model_check("pair");
    end
    check("pair level", 32'(bs_level), 32'd3);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      b_clr     = ($urandom_range(0, 31) == 0);
      b_wr_en   = ($urandom_range(0, 99) < 55);
      b_rd_en   = ($urandom_range(0, 99) < 50);
      b_wr_data = $urandom;
      b_cycle();
      model_check("rand");
    end
    b_clr = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
